// File: rtl/sccb_responder_if.sv
// SCCB/I2C bus as seen by the camera-side responder: SCL and pad-level SDA
// come in, an open-drain pull-down enable goes out.
interface sccb_responder_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe_o;

  modport slave  (input scl_i, input sda_i, output sda_oe_o);
  modport master (output scl_i, output sda_i, input sda_oe_o);
endinterface

// File: rtl/sccb_responder.sv
// Camera-side SCCB/I2C target. SCL/SDA are oversampled on clk_i, START/STOP
// are decoded in every state, the 7-bit device address is matched, and an
// 8-bit register file is written or read back through an auto-incrementing
// pointer. A combinational side port exposes the register file.
module sccb_responder #(
  parameter logic [6:0] DEV_ADDR_P = 7'h21,
  parameter int         NREGS_P    = 256
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  sccb_responder_if.slave     sccb,
  output logic                reg_wr_o,
  output logic [7:0]          reg_addr_o,
  output logic [7:0]          reg_wdata_o,
  input  logic [7:0]          dbg_addr_i,
  output logic [7:0]          dbg_data_o,
  output logic                busy_o
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV, ST_DEV_ACK, ST_REG, ST_REG_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RD_MACK, ST_IGNORE
  } state_t;

  // Indices at or above NREGS_P have no storage and read as zero.
  function automatic logic f_exists(input logic [7:0] idx);
    return {24'd0, idx} < NREGS_P;
  endfunction

  logic       r_scl_meta, r_scl_sync, r_scl_hist;
  logic       r_sda_meta, r_sda_sync, r_sda_hist;

  state_t     r_state, w_state_nxt;
  logic [6:0] r_shift, w_shift_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic       r_rnw, w_rnw_nxt;
  logic [7:0] r_ptr, w_ptr_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_ack_on, w_ack_on_nxt;
  logic [7:0] r_rd_byte, w_rd_byte_nxt;
  logic       r_rd_done, w_rd_done_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_wr, w_wr_nxt;
  logic [7:0] r_wdata, w_wdata_nxt;

  logic [7:0] r_regs [NREGS_P];

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;
  logic [7:0] w_ptr_inc;
  logic [7:0] w_rd_cur, w_rd_next;

  assign w_scl_rise = r_scl_sync & ~r_scl_hist;
  assign w_scl_fall = ~r_scl_sync & r_scl_hist;
  assign w_start    = r_scl_sync & r_scl_hist & r_sda_hist & ~r_sda_sync;
  assign w_stop     = r_scl_sync & r_scl_hist & ~r_sda_hist & r_sda_sync;

  // Byte as it stands once the bit sampled on this SCL rise is shifted in.
  assign w_byte    = {r_shift, r_sda_sync};
  assign w_ptr_inc = r_ptr + 8'd1;
  assign w_rd_cur  = f_exists(r_ptr)     ? r_regs[r_ptr]     : 8'h00;
  assign w_rd_next = f_exists(w_ptr_inc) ? r_regs[w_ptr_inc] : 8'h00;

  assign sccb.sda_oe_o = r_sda_oe;
  assign reg_wr_o      = r_wr;
  assign reg_addr_o    = r_ptr;
  assign reg_wdata_o   = r_wdata;
  assign busy_o        = r_busy;
  assign dbg_data_o    = f_exists(dbg_addr_i) ? r_regs[dbg_addr_i] : 8'h00;

  // Two-flop synchronizers plus one history flop per bus line; idle bus is high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n_i) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_hist <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_meta <= sccb.scl_i;
      r_scl_sync <= r_scl_meta;
      r_scl_hist <= r_scl_sync;
      r_sda_meta <= sccb.sda_i;
      r_sda_sync <= r_sda_meta;
      r_sda_hist <= r_sda_sync;
    end
  end

  // Protocol state and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_rnw     <= 1'b0;
      r_ptr     <= '0;
      r_sda_oe  <= 1'b0;
      r_ack_on  <= 1'b0;
      r_rd_byte <= '0;
      r_rd_done <= 1'b0;
      r_busy    <= 1'b0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_rnw     <= w_rnw_nxt;
      r_ptr     <= w_ptr_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      r_ack_on  <= w_ack_on_nxt;
      r_rd_byte <= w_rd_byte_nxt;
      r_rd_done <= w_rd_done_nxt;
      r_busy    <= w_busy_nxt;
      r_wr      <= w_wr_nxt;
      r_wdata   <= w_wdata_nxt;
    end
  end

  // Register file: committed at the end of the strobe cycle, so a same-cycle
  // side-port read of the target index still returns the old contents.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: the register file must read 0x00 after reset, so this memory is deliberately reset.
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS_P; i++) r_regs[i] <= 8'h00;
    end else if (r_wr && f_exists(r_ptr)) begin
      r_regs[r_ptr] <= r_wdata;
    end
  end

  // Next-state and datapath decisions; START/STOP override every state.
  always_comb begin
    // NOTE: every target gets a default here so no path can infer a latch.
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_rnw_nxt     = r_rnw;
    w_ptr_nxt     = r_ptr;
    w_sda_oe_nxt  = r_sda_oe;
    w_ack_on_nxt  = r_ack_on;
    w_rd_byte_nxt = r_rd_byte;
    w_rd_done_nxt = r_rd_done;
    w_busy_nxt    = r_busy;
    w_wr_nxt      = 1'b0;
    w_wdata_nxt   = r_wdata;

    if (w_start) begin
      w_state_nxt   = ST_DEV;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
      w_ack_on_nxt  = 1'b0;
      w_rd_done_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt   = ST_IDLE;
      w_sda_oe_nxt  = 1'b0;
      w_ack_on_nxt  = 1'b0;
      w_rd_done_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        ST_DEV: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte[6:0];
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_rnw_nxt = w_byte[0];
              if (w_byte[7:1] == DEV_ADDR_P) begin
                w_state_nxt = ST_DEV_ACK;
                w_busy_nxt  = 1'b1;
              end else begin
                w_state_nxt = ST_IGNORE;
                w_busy_nxt  = 1'b0;
              end
            end
          end
        end

        // ACK slot: pull low on the first SCL fall, release on the next one.
        ST_DEV_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_on) begin
              w_sda_oe_nxt = 1'b1;
              w_ack_on_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt  = 1'b0;
              w_ack_on_nxt  = 1'b0;
              w_bit_cnt_nxt = '0;
              if (r_state == ST_DEV_ACK) begin
                if (r_rnw) begin
                  // The release fall is also the drive point of the first data bit.
                  w_state_nxt   = ST_RDATA;
                  w_sda_oe_nxt  = ~w_rd_cur[7];
                  w_rd_byte_nxt = {w_rd_cur[6:0], 1'b0};
                  w_rd_done_nxt = 1'b0;
                end else begin
                  w_state_nxt = ST_REG;
                end
              end else if (r_state == ST_REG_ACK) begin
                w_state_nxt = ST_WDATA;
              end else begin
                w_state_nxt = ST_WDATA;
                w_ptr_nxt   = w_ptr_inc;
              end
            end
          end
        end

        ST_REG: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte[6:0];
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_ptr_nxt   = w_byte;
              w_state_nxt = ST_REG_ACK;
            end
          end
        end

        ST_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte[6:0];
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_wr_nxt    = 1'b1;
              w_wdata_nxt = w_byte;
              w_state_nxt = ST_WDATA_ACK;
            end
          end
        end

        // Drive one bit per SCL fall; after the 8th bit is sampled, release.
        ST_RDATA: begin
          if (w_scl_fall) begin
            if (r_rd_done) begin
              w_sda_oe_nxt  = 1'b0;
              w_rd_done_nxt = 1'b0;
              w_state_nxt   = ST_RD_MACK;
            end else begin
              w_sda_oe_nxt  = ~r_rd_byte[7];
              w_rd_byte_nxt = {r_rd_byte[6:0], 1'b0};
            end
          end else if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) w_rd_done_nxt = 1'b1;
          end
        end

        ST_RD_MACK: begin
          if (w_scl_rise) begin
            if (!r_sda_sync) begin
              w_ptr_nxt     = w_ptr_inc;
              w_rd_byte_nxt = w_rd_next;
              w_bit_cnt_nxt = '0;
              w_rd_done_nxt = 1'b0;
              w_state_nxt   = ST_RDATA;
            end else begin
              w_state_nxt = ST_IGNORE;
              w_busy_nxt  = 1'b0;
            end
          end
        end

        ST_IDLE, ST_IGNORE: begin
        end

        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule
